// File: rtl/demux_reg_bank_pkg.sv
// demux_reg_bank_pkg
// Shared types and constants for the 14-way write distributor that feeds the
// output selector: default sizes, the 4-bit address type, FSM state encoding,
// and the wrap/range helpers used by both the top level and the burst
// address generator.
package demux_reg_bank_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_NREGS = 14;

    typedef logic [3:0] addr_t;

    // Highest legal register address; bursts wrap from here back to 0.
    localparam addr_t LAST_ADDR = addr_t'(DEFAULT_NREGS - 1);

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StBurst = 1'b1
    } state_e;

    function automatic addr_t next_addr(input addr_t a);
        return (a == LAST_ADDR) ? addr_t'(0) : a + addr_t'(1);
    endfunction

    function automatic logic addr_legal(input addr_t a);
        return a <= LAST_ADDR;
    endfunction

endpackage

// File: rtl/demux_reg_bank_if.sv
// demux_reg_bank_if
// Bundles the write bus, the status pulses and the 14 register outputs of
// demux_reg_bank.
//   master : drives Clear/WrEn/WrAddr/WrData/BurstStart/BurstLen,
//            observes Out0..Out13, WrAck, AddrErr, Busy, Done
//   slave  : the register bank (opposite directions)
interface demux_reg_bank_if #(
    parameter int unsigned WIDTH = demux_reg_bank_pkg::DEFAULT_WIDTH
);

    logic                         Clear;
    logic                         WrEn;
    demux_reg_bank_pkg::addr_t    WrAddr;
    logic [WIDTH-1:0]             WrData;
    logic                         BurstStart;
    logic [3:0]                   BurstLen;

    logic [WIDTH-1:0] Out0,  Out1,  Out2,  Out3,  Out4,  Out5,  Out6;
    logic [WIDTH-1:0] Out7,  Out8,  Out9,  Out10, Out11, Out12, Out13;

    logic                         WrAck;
    logic                         AddrErr;
    logic                         Busy;
    logic                         Done;

    modport master (
        output Clear, WrEn, WrAddr, WrData, BurstStart, BurstLen,
        input  Out0, Out1, Out2, Out3, Out4, Out5, Out6,
        input  Out7, Out8, Out9, Out10, Out11, Out12, Out13,
        input  WrAck, AddrErr, Busy, Done
    );

    modport slave (
        input  Clear, WrEn, WrAddr, WrData, BurstStart, BurstLen,
        output Out0, Out1, Out2, Out3, Out4, Out5, Out6,
        output Out7, Out8, Out9, Out10, Out11, Out12, Out13,
        output WrAck, AddrErr, Busy, Done
    );

endinterface

// File: rtl/demux_reg_bank_burst_addr_gen.sv
// demux_reg_bank_burst_addr_gen
// Burst pointer and beat counter.
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture start_addr/len (start of a burst)
//   load_beat  : a data beat is consumed in the same cycle as load
//   start_addr : burst start address
//   len        : beat count minus one
//   advance    : consume one beat (pointer +1 with wrap, count -1)
//   ptr        : address of the next beat
//   last       : the next beat is the final one of the burst
module demux_reg_bank_burst_addr_gen
    import demux_reg_bank_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  load_beat,
    input  addr_t start_addr,
    input  logic  [3:0] len,
    input  logic  advance,
    output addr_t ptr,
    output logic  last
);

    addr_t      ptr_q;
    logic [3:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            // A beat taken alongside BurstStart is beat 0, so skip past it.
            ptr_q <= load_beat ? next_addr(start_addr) : start_addr;
            cnt_q <= load_beat ? len - 4'd1 : len;
        end else if (advance) begin
            ptr_q <= next_addr(ptr_q);
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign ptr  = ptr_q;
    assign last = (cnt_q == 4'd0);

endmodule

// File: rtl/demux_reg_bank.sv
// demux_reg_bank
// Distributes 8-bit writes into 14 registered outputs that feed the output
// selector. Supports single addressed writes and auto-incrementing bursts
// that wrap from register 13 to register 0.
//   Clk   : rising-edge clock
//   Reset : synchronous active-high reset, overrides everything
//   bus   : write bus, register outputs Out0..Out13 and status pulses
//           (WrAck, AddrErr, Done one cycle after the sampling edge; Busy
//           high while a burst is in progress)
// The output port list is fixed at 14 registers; NREGS must stay 14.
module demux_reg_bank
    import demux_reg_bank_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned NREGS = DEFAULT_NREGS
) (
    input  logic             Clk,
    input  logic             Reset,
    demux_reg_bank_if.slave  bus
);

    state_e state_q, state_d;

    logic [WIDTH-1:0] regs_q [NREGS];

    logic  wr_go;
    addr_t wr_idx;
    logic  ack_d, err_d, done_d;
    logic  ack_q, err_q, done_q;

    logic  gen_load, gen_load_beat, gen_advance;
    addr_t gen_ptr;
    logic  gen_last;

    demux_reg_bank_burst_addr_gen u_addr_gen (
        .clk        (Clk),
        .rst        (Reset),
        .load       (gen_load),
        .load_beat  (gen_load_beat),
        .start_addr (bus.WrAddr),
        .len        (bus.BurstLen),
        .advance    (gen_advance),
        .ptr        (gen_ptr),
        .last       (gen_last)
    );

    always_comb begin
        state_d       = state_q;
        wr_go         = 1'b0;
        wr_idx        = bus.WrAddr;
        gen_load      = 1'b0;
        gen_load_beat = 1'b0;
        gen_advance   = 1'b0;
        ack_d         = 1'b0;
        err_d         = 1'b0;
        done_d        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.BurstStart) begin
                    if (addr_legal(bus.WrAddr)) begin
                        if (bus.WrEn) begin
                            wr_go = 1'b1;
                            ack_d = 1'b1;
                            if (bus.BurstLen == 4'd0) begin
                                // One-beat burst finishes right here.
                                done_d = 1'b1;
                            end else begin
                                gen_load      = 1'b1;
                                gen_load_beat = 1'b1;
                                state_d       = StBurst;
                            end
                        end else begin
                            gen_load = 1'b1;
                            state_d  = StBurst;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (bus.WrEn) begin
                    if (addr_legal(bus.WrAddr)) begin
                        wr_go = 1'b1;
                        ack_d = 1'b1;
                    end else begin
                        // Illegal address: bank holds, like the selector does.
                        err_d = 1'b1;
                    end
                end
            end

            StBurst: begin
                if (bus.WrEn) begin
                    wr_go       = 1'b1;
                    wr_idx      = gen_ptr;
                    ack_d       = 1'b1;
                    gen_advance = 1'b1;
                    if (gen_last) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Clear wins over a same-cycle write; the beat is still consumed above.
    always_ff @(posedge Clk) begin
        if (Reset || bus.Clear) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_go) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                if (wr_idx == addr_t'(i)) begin
                    regs_q[i] <= bus.WrData;
                end
            end
        end
    end

    assign bus.WrAck   = ack_q;
    assign bus.AddrErr = err_q;
    assign bus.Done    = done_q;
    assign bus.Busy    = (state_q == StBurst);

    assign bus.Out0  = regs_q[0];
    assign bus.Out1  = regs_q[1];
    assign bus.Out2  = regs_q[2];
    assign bus.Out3  = regs_q[3];
    assign bus.Out4  = regs_q[4];
    assign bus.Out5  = regs_q[5];
    assign bus.Out6  = regs_q[6];
    assign bus.Out7  = regs_q[7];
    assign bus.Out8  = regs_q[8];
    assign bus.Out9  = regs_q[9];
    assign bus.Out10 = regs_q[10];
    assign bus.Out11 = regs_q[11];
    assign bus.Out12 = regs_q[12];
    assign bus.Out13 = regs_q[13];

endmodule

// File: tb/tb_demux_reg_bank.sv
// tb_demux_reg_bank
// Directed bench for demux_reg_bank. Stimulus pushes the expected status
// pulse (with the cycle it must appear in) into a queue; a monitor pops and
// compares whenever WrAck/AddrErr/Done is seen. Register contents are
// compared against a hand-maintained model array.
module tb_demux_reg_bank;

    logic clk;
    logic reset;
    int   cyc;
    int   busy_cnt;
    int   checks;
    int   failures;

    typedef struct {
        int cyc;
        bit ack;
        bit err;
        bit done;
    } exp_t;

    exp_t exp_q[$];

    logic [7:0] model [14];
    logic [7:0] outs  [14];

    demux_reg_bank_if #(.WIDTH(8)) bus ();

    demux_reg_bank #(
        .WIDTH (8),
        .NREGS (14)
    ) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus)
    );

    assign outs[0]  = bus.Out0;
    assign outs[1]  = bus.Out1;
    assign outs[2]  = bus.Out2;
    assign outs[3]  = bus.Out3;
    assign outs[4]  = bus.Out4;
    assign outs[5]  = bus.Out5;
    assign outs[6]  = bus.Out6;
    assign outs[7]  = bus.Out7;
    assign outs[8]  = bus.Out8;
    assign outs[9]  = bus.Out9;
    assign outs[10] = bus.Out10;
    assign outs[11] = bus.Out11;
    assign outs[12] = bus.Out12;
    assign outs[13] = bus.Out13;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Counts cycles during which Busy was high (sampled before each edge).
    initial busy_cnt = 0;
    always @(posedge clk) begin
        if (bus.Busy === 1'b1) busy_cnt <= busy_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every status pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.WrAck === 1'b1 || bus.AddrErr === 1'b1 || bus.Done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {29'd0, bus.WrAck, bus.AddrErr, bus.Done}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_cycle", cyc, e.cyc);
                chk("pulse_flags", {29'd0, bus.WrAck, bus.AddrErr, bus.Done},
                    {29'd0, e.ack, e.err, e.done});
            end
        end
    end

    // Drive one cycle of inputs (called at a negedge) and queue the response.
    task automatic issue(input bit we, input logic [3:0] addr, input logic [7:0] data,
                         input bit bs, input logic [3:0] len, input bit clr,
                         input bit e_ack, input bit e_err, input bit e_done);
        exp_t e;
        bus.WrEn       = we;
        bus.WrAddr     = addr;
        bus.WrData     = data;
        bus.BurstStart = bs;
        bus.BurstLen   = len;
        bus.Clear      = clr;
        if (e_ack || e_err || e_done) begin
            e.cyc  = cyc + 1;
            e.ack  = e_ack;
            e.err  = e_err;
            e.done = e_done;
            exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(0, 4'd0, 8'h00, 0, 4'd0, 0, 0, 0, 0);
    endtask

    task automatic check_outs(input string tag);
        for (int i = 0; i < 14; i++) begin
            chk($sformatf("%s_out%0d", tag, i), {24'd0, outs[i]}, {24'd0, model[i]});
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 14; i++) model[i] = 8'h00;
    endtask

    initial begin
        int b0;
        checks   = 0;
        failures = 0;
        clear_model();
        reset          = 1'b1;
        bus.WrEn       = 1'b0;
        bus.WrAddr     = 4'd0;
        bus.WrData     = 8'h00;
        bus.BurstStart = 1'b0;
        bus.BurstLen   = 4'd0;
        bus.Clear      = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state.
        check_outs("reset");
        chk("reset_busy", {31'd0, bus.Busy}, 32'd0);
        chk("reset_pulses", {29'd0, bus.WrAck, bus.AddrErr, bus.Done}, 32'd0);
        reset = 1'b0;
        idle(1);

        // Single writes.
        issue(1, 4'd3,  8'hA5, 0, 4'd0, 0, 1, 0, 0);
        issue(1, 4'd13, 8'h3C, 0, 4'd0, 0, 1, 0, 0);
        idle(1);
        model[3]  = 8'hA5;
        model[13] = 8'h3C;
        check_outs("single");

        // Illegal single write.
        issue(1, 4'd14, 8'hFF, 0, 4'd0, 0, 0, 1, 0);
        idle(1);
        check_outs("addr14");

        // Burst 12..1 with wrap; WrAddr during the burst must be ignored.
        b0 = busy_cnt;
        issue(0, 4'd12, 8'h00, 1, 4'd3, 0, 0, 0, 0);
        issue(1, 4'd15, 8'h10, 0, 4'd0, 0, 1, 0, 0);
        issue(1, 4'd15, 8'h11, 0, 4'd0, 0, 1, 0, 0);
        issue(1, 4'd15, 8'h12, 0, 4'd0, 0, 1, 0, 0);
        issue(1, 4'd15, 8'h13, 0, 4'd0, 0, 1, 0, 1);
        idle(2);
        model[12] = 8'h10;
        model[13] = 8'h11;
        model[0]  = 8'h12;
        model[1]  = 8'h13;
        check_outs("burst");
        chk("burst_busy_cycles", busy_cnt - b0, 32'd4);

        // Same burst with a two-cycle stall.
        b0 = busy_cnt;
        issue(0, 4'd12, 8'h00, 1, 4'd3, 0, 0, 0, 0);
        issue(1, 4'd0,  8'h10, 0, 4'd0, 0, 1, 0, 0);
        issue(1, 4'd0,  8'h11, 0, 4'd0, 0, 1, 0, 0);
        idle(2);
        issue(1, 4'd0,  8'h12, 0, 4'd0, 0, 1, 0, 0);
        issue(1, 4'd0,  8'h13, 0, 4'd0, 0, 1, 0, 1);
        idle(2);
        check_outs("stall");
        chk("stall_busy_cycles", busy_cnt - b0, 32'd6);

        // BurstStart at an illegal address: error, no burst.
        b0 = busy_cnt;
        issue(1, 4'd15, 8'hEE, 1, 4'd2, 0, 0, 1, 0);
        idle(2);
        check_outs("bs_illegal");
        chk("bs_illegal_busy", busy_cnt - b0, 32'd0);

        // One-beat burst with data on the start cycle.
        b0 = busy_cnt;
        issue(1, 4'd9, 8'h99, 1, 4'd0, 0, 1, 0, 1);
        idle(1);
        model[9] = 8'h99;
        check_outs("one_beat");
        chk("one_beat_busy", busy_cnt - b0, 32'd0);

        // 16-beat burst from 0 rewrites Out0 and Out1.
        issue(0, 4'd0, 8'h00, 1, 4'd15, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            issue(1, 4'd7, 8'h80 + 8'(i), 0, 4'd0, 0, 1, 0, (i == 15));
        end
        idle(1);
        for (int i = 2; i < 14; i++) model[i] = 8'h80 + 8'(i);
        model[0] = 8'h8E;
        model[1] = 8'h8F;
        check_outs("wrap16");

        // Clear wins over a same-cycle write, but the beat is acknowledged.
        issue(1, 4'd5, 8'h77, 0, 4'd0, 1, 1, 0, 0);
        idle(1);
        clear_model();
        check_outs("clear");
        issue(1, 4'd5, 8'h77, 0, 4'd0, 0, 1, 0, 0);
        idle(1);
        model[5] = 8'h77;
        check_outs("after_clear");

        // Reset after beat 2 of a 5-beat burst (beat 0 on the start cycle).
        issue(1, 4'd2, 8'h21, 1, 4'd4, 0, 1, 0, 0);
        issue(1, 4'd0, 8'h22, 0, 4'd0, 0, 1, 0, 0);
        issue(1, 4'd0, 8'h23, 0, 4'd0, 0, 1, 0, 0);
        reset = 1'b1;
        issue(1, 4'd0, 8'h24, 0, 4'd0, 0, 0, 0, 0);
        reset = 1'b0;
        clear_model();
        check_outs("burst_reset");
        chk("burst_reset_busy", {31'd0, bus.Busy}, 32'd0);
        idle(3);
        issue(1, 4'd7, 8'h5A, 0, 4'd0, 0, 1, 0, 0);
        idle(1);
        model[7] = 8'h5A;
        check_outs("post_reset");

        idle(3);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
